ir_nec_receiver: RTL and testbench
==================================

IR_NEC_RECEIVER -- requirements
Module: ir_nec_receiver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1_000_000, meaning the clock frequency used to derive a 1 us timebase.
REQ-002 SHALL have port clock, input, 1, the single system clock.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port ir_signal, input, 1: the demodulated IR receiver output, asynchronous, active-low (low = carrier burst, "mark").
REQ-005 SHALL have port ir_data, output, 32: the last valid frame, first-received bit in [0].
REQ-006 SHALL have port avail, output, 1: one-cycle pulse, coincident with the ir_data update.
REQ-007 SHALL have port rpt, output, 1: one-cycle pulse on a valid NEC repeat code.
REQ-008 SHALL have port frame_err, output, 1: one-cycle pulse when an accepted frame is aborted.
REQ-009 SHALL have port cmd_ok, output, 1: registered flag, ir_data[23:16] == ~ir_data[31:24].

Function
REQ-010 SHALL pass ir_signal through a 2-flop synchronizer, then detect mark start and mark end edges; edge-to-state latency 3 clocks max.
REQ-011 SHALL divide clock by CLK_HZ/1_000_000 into a 1 us tick and count phase duration in a 14-bit saturating us counter, cleared on every synchronized edge.
REQ-012 SHALL implement FSM states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_STOP.
REQ-013 IDLE SHALL go to LEAD_MARK on mark start, with no outputs.
REQ-014 LEAD_MARK SHALL go to LEAD_SPACE on mark end if duration is 8000..10000 us; otherwise it returns to IDLE silently (noise rejection, no frame_err).
REQ-015 LEAD_SPACE, on mark start, SHALL:
- go to BIT_MARK if duration is 4000..5000 us, clearing the shift register and bit count;
- go to RPT_STOP if duration is 1800..2700 us;
- otherwise raise frame_err.
REQ-016 BIT_MARK SHALL accept 400..750 us and go to BIT_SPACE.
REQ-017 BIT_SPACE SHALL decode a space of 400..750 us as 0 and 1400..1900 us as 1.
- The bit shifts in LSB-first (bit k to shift reg [k]) and the 6-bit count increments.
- Next state is BIT_MARK while count < 32, else STOP_MARK.
REQ-018 STOP_MARK SHALL, on mark end with 400..750 us, load ir_data, update cmd_ok, pulse avail, and go to IDLE.
REQ-019 RPT_STOP SHALL, on mark end with 400..750 us, pulse rpt and go to IDLE; ir_data is unchanged.
REQ-020 Any out-of-window duration in states after LEAD_MARK SHALL pulse frame_err and go to IDLE without altering ir_data or cmd_ok.
REQ-021 Timeout: the counter reaching 11000 us in any non-IDLE state SHALL pulse frame_err (except in LEAD_MARK, which returns silently) and go to IDLE.
- Return to IDLE requires the line to be idle (space); a stuck mark waits in IDLE until mark end.
REQ-022 avail, rpt and frame_err SHALL be mutually exclusive and never high for more than 1 cycle per event.
REQ-023 Window bounds SHALL be inclusive; a boundary equal to a limit is accepted.

Reset
REQ-024 Asserting reset_n low SHALL asynchronously force FSM=IDLE, counters=0, synchronizer flops=1 (idle level), and ir_data=0, avail=0, rpt=0, frame_err=0, cmd_ok=0.
REQ-025 Reset mid-frame SHALL discard partial bits; the first frame after release SHALL decode normally.

Structure
REQ-026 Package ir_pkg SHALL hold the FSM state enum and all us window constants (LEAD_MARK_MIN/MAX, LEAD_SPACE_MIN/MAX, RPT_SPACE_MIN/MAX, BIT_MARK_MIN/MAX, ZERO_SPACE/ONE_SPACE MIN/MAX, TIMEOUT_US).
REQ-027 Sub-module ir_edge_sync SHALL contain the synchronizer and edge detector, outputting mark_start, mark_end and mark_level.

Verification
REQ-028 NEC frame addr 0x00, cmd 0x45 at nominal timing -> ir_data=32'hBA45FF00, cmd_ok=1, one avail pulse, no frame_err.
REQ-029 Valid frame, then 9000 us mark / 2250 us space / 560 us mark -> one rpt pulse, ir_data stays 32'hBA45FF00.
REQ-030 Frame whose bit-10 space is 1000 us -> one frame_err pulse, no avail, ir_data unchanged.
REQ-031 200 us mark while IDLE -> no avail, rpt or frame_err; next full frame decodes.
REQ-032 reset_n low during bit 20, then release and send a frame with cmd 0x16 -> ir_data=32'hE916FF00, avail pulse.
REQ-033 Leader accepted, then space held for 12000 us -> frame_err pulse at 11000 us, FSM=IDLE.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and microsecond timing windows for the NEC IR receiver.
// Each window is inclusive at both ends.
package ir_pkg;

    localparam int DUR_W = 14;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        RPT_STOP
    } state_t;

    // What the FSM decided this cycle; the output process turns it into datapath updates.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_ERR,
        ACT_CLEAR,
        ACT_BIT0,
        ACT_BIT1,
        ACT_LOAD,
        ACT_RPT
    } action_t;

    localparam logic [DUR_W-1:0] LEAD_MARK_MIN  = 14'd8000;
    localparam logic [DUR_W-1:0] LEAD_MARK_MAX  = 14'd10000;
    localparam logic [DUR_W-1:0] LEAD_SPACE_MIN = 14'd4000;
    localparam logic [DUR_W-1:0] LEAD_SPACE_MAX = 14'd5000;
    localparam logic [DUR_W-1:0] RPT_SPACE_MIN  = 14'd1800;
    localparam logic [DUR_W-1:0] RPT_SPACE_MAX  = 14'd2700;
    localparam logic [DUR_W-1:0] BIT_MARK_MIN   = 14'd400;
    localparam logic [DUR_W-1:0] BIT_MARK_MAX   = 14'd750;
    localparam logic [DUR_W-1:0] ZERO_SPACE_MIN = 14'd400;
    localparam logic [DUR_W-1:0] ZERO_SPACE_MAX = 14'd750;
    localparam logic [DUR_W-1:0] ONE_SPACE_MIN  = 14'd1400;
    localparam logic [DUR_W-1:0] ONE_SPACE_MAX  = 14'd1900;
    localparam logic [DUR_W-1:0] TIMEOUT_US     = 14'd11000;

    function automatic logic in_window(input logic [DUR_W-1:0] d,
                                       input logic [DUR_W-1:0] lo,
                                       input logic [DUR_W-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchronizer for the asynchronous IR line plus mark start/end edge detection.
// Flops power up at the idle (high) level so reset never produces a spurious edge.
module ir_edge_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic ir_signal,
    output logic mark_start,
    output logic mark_end,
    output logic mark_level
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], ir_signal};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign mark_level = ~sync_q[1];
    assign mark_start = prev_q & ~sync_q[1];
    assign mark_end   = ~prev_q & sync_q[1];

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR frame decoder: measures mark/space durations in microseconds and
// walks a leader / 32-bit / stop (or repeat) FSM, pulsing avail, rpt or frame_err.
module ir_nec_receiver #(
    parameter int CLK_HZ = 1_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ir_signal,
    output logic [31:0] ir_data,
    output logic        avail,
    output logic        rpt,
    output logic        frame_err,
    output logic        cmd_ok
);
    import ir_pkg::*;

    // Clocks at or above 1 MHz divide down to a 1 us tick; slower clocks advance several us per cycle.
    localparam int CYC_PER_US = (CLK_HZ >= 1_000_000) ? CLK_HZ / 1_000_000 : 1;
    localparam int US_PER_CYC = (CLK_HZ >= 1_000_000) ? 1 : 1_000_000 / CLK_HZ;
    localparam int PRE_W      = $clog2(CYC_PER_US + 1);
    localparam int SUM_W      = DUR_W + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_US - 1);
    localparam logic [SUM_W-1:0] STEP     = SUM_W'(US_PER_CYC);

    logic mark_start, mark_end, mark_level;
    logic edge_seen, mark_done, space_done, tick;

    state_t            state_q, state_d;
    action_t           action;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [SUM_W-1:0]  dur_sum;
    logic [31:0]       shift_q, shift_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [31:0]       ir_data_q, ir_data_d;
    logic              cmd_ok_q, cmd_ok_d;
    logic              avail_q, avail_d, rpt_q, rpt_d, err_q, err_d;

    ir_edge_sync u_sync (
        .clock      (clock),
        .reset_n    (reset_n),
        .ir_signal  (ir_signal),
        .mark_start (mark_start),
        .mark_end   (mark_end),
        .mark_level (mark_level)
    );

    assign edge_seen  = mark_start | mark_end;
    assign mark_done  = edge_seen & ~mark_level;
    assign space_done = edge_seen & mark_level;
    assign tick       = (pre_q == PRE_LAST);
    assign dur_sum    = {1'b0, dur_q} + STEP;

    // The edge cycle is the first cycle of the new phase, so a phase of N us reads back as exactly N.
    always_comb begin
        pre_d = pre_q;
        dur_d = dur_q;
        if (edge_seen) begin
            if (CYC_PER_US == 1) begin
                pre_d = '0;
                dur_d = STEP[DUR_W-1:0];
            end else begin
                pre_d = PRE_W'(1);
                dur_d = '0;
            end
        end else if (tick) begin
            pre_d = '0;
            dur_d = dur_sum[DUR_W] ? {DUR_W{1'b1}} : dur_sum[DUR_W-1:0];
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        action  = ACT_NONE;
        if ((state_q != IDLE) && (dur_q >= TIMEOUT_US)) begin
            state_d = IDLE;
            action  = (state_q == LEAD_MARK) ? ACT_NONE : ACT_ERR;
        end else begin
            case (state_q)
                IDLE: if (space_done) state_d = LEAD_MARK;
                LEAD_MARK: if (mark_done) begin
                    state_d = in_window(dur_q, LEAD_MARK_MIN, LEAD_MARK_MAX) ? LEAD_SPACE : IDLE;
                end
                LEAD_SPACE: if (space_done) begin
                    if (in_window(dur_q, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                        state_d = BIT_MARK;
                        action  = ACT_CLEAR;
                    end else if (in_window(dur_q, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                        state_d = RPT_STOP;
                    end else begin
                        state_d = IDLE;
                        action  = ACT_ERR;
                    end
                end
                BIT_MARK: if (mark_done) begin
                    if (in_window(dur_q, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        state_d = BIT_SPACE;
                    end else begin
                        state_d = IDLE;
                        action  = ACT_ERR;
                    end
                end
                BIT_SPACE: if (space_done) begin
                    if (in_window(dur_q, ZERO_SPACE_MIN, ZERO_SPACE_MAX)) begin
                        action = ACT_BIT0;
                    end else if (in_window(dur_q, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                        action = ACT_BIT1;
                    end else begin
                        action = ACT_ERR;
                    end
                    if (action == ACT_ERR) state_d = IDLE;
                    else state_d = (bit_cnt_q < 6'd31) ? BIT_MARK : STOP_MARK;
                end
                STOP_MARK, RPT_STOP: if (mark_done) begin
                    state_d = IDLE;
                    if (!in_window(dur_q, BIT_MARK_MIN, BIT_MARK_MAX)) action = ACT_ERR;
                    else action = (state_q == STOP_MARK) ? ACT_LOAD : ACT_RPT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ir_data_d = ir_data_q;
        cmd_ok_d  = cmd_ok_q;
        avail_d   = 1'b0;
        rpt_d     = 1'b0;
        err_d     = 1'b0;
        case (action)
            ACT_CLEAR: begin
                shift_d   = '0;
                bit_cnt_d = '0;
            end
            ACT_BIT0, ACT_BIT1: begin
                shift_d[bit_cnt_q[4:0]] = (action == ACT_BIT1);
                bit_cnt_d               = bit_cnt_q + 6'd1;
            end
            ACT_LOAD: begin
                ir_data_d = shift_q;
                cmd_ok_d  = (shift_q[23:16] == ~shift_q[31:24]);
                avail_d   = 1'b1;
            end
            ACT_RPT: rpt_d = 1'b1;
            ACT_ERR: err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            dur_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ir_data_q <= '0;
            cmd_ok_q  <= 1'b0;
            avail_q   <= 1'b0;
            rpt_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            dur_q     <= dur_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ir_data_q <= ir_data_d;
            cmd_ok_q  <= cmd_ok_d;
            avail_q   <= avail_d;
            rpt_q     <= rpt_d;
            err_q     <= err_d;
        end
    end

    assign ir_data   = ir_data_q;
    assign cmd_ok    = cmd_ok_q;
    assign avail     = avail_q;
    assign rpt       = rpt_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Bench for ir_nec_receiver: table of NEC frames / repeats / noise with expected pulse counts,
// plus hand-written timeout and mid-frame reset sequences. One clock cycle is 10 us.
module tb_ir_nec_receiver;

    localparam int CLK_HZ     = 100_000;
    localparam int US_PER_CYC = 10;
    localparam int K_FRAME    = 0;
    localparam int K_RPT      = 1;
    localparam int K_NOISE    = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] data;
        int          lead_mark;
        int          lead_space;
        int          bit_mark;
        int          zero_sp;
        int          one_sp;
        int          nbits;
        int          bad_bit;
        int          bad_sp;
        int          exp_avail;
        int          exp_rpt;
        int          exp_err;
        logic [31:0] exp_data;
        logic        exp_ok;
    } vec_t;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        ir_signal = 1'b1;
    logic [31:0] ir_data;
    logic        avail, rpt, frame_err, cmd_ok;

    int checks = 0;
    int passes = 0;
    int avail_cnt = 0, rpt_cnt = 0, err_cnt = 0;
    int excl_viol = 0, width_viol = 0, data_viol = 0;
    logic        avail_p = 1'b0, rpt_p = 1'b0, err_p = 1'b0;
    logic [31:0] data_p = '0;

    vec_t vecs[18];

    always #5 clock = ~clock;

    ir_nec_receiver #(.CLK_HZ(CLK_HZ)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ir_signal (ir_signal),
        .ir_data   (ir_data),
        .avail     (avail),
        .rpt       (rpt),
        .frame_err (frame_err),
        .cmd_ok    (cmd_ok)
    );

    // Pulse counting plus exclusivity, one-cycle width and ir_data-only-with-avail monitoring.
    always @(negedge clock) begin
        if (reset_n) begin
            if (avail) avail_cnt++;
            if (rpt) rpt_cnt++;
            if (frame_err) err_cnt++;
            if (int'(avail) + int'(rpt) + int'(frame_err) > 1) excl_viol++;
            if ((avail && avail_p) || (rpt && rpt_p) || (frame_err && err_p)) width_viol++;
            if ((ir_data !== data_p) && !avail) data_viol++;
        end
        avail_p = avail;
        rpt_p   = rpt;
        err_p   = frame_err;
        data_p  = ir_data;
    end

    function automatic logic [31:0] nec_word(input logic [7:0] addr, input logic [7:0] cmd);
        return {~cmd, cmd, ~addr, addr};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic hold(input logic level, input int us);
        ir_signal = level;
        repeat (us / US_PER_CYC) @(negedge clock);
    endtask

    task automatic apply_stimulus(input vec_t v);
        case (v.kind)
            K_FRAME: begin
                hold(1'b0, v.lead_mark);
                hold(1'b1, v.lead_space);
                for (int k = 0; k < v.nbits; k++) begin
                    hold(1'b0, v.bit_mark);
                    if (k == v.bad_bit) hold(1'b1, v.bad_sp);
                    else if (v.data[k]) hold(1'b1, v.one_sp);
                    else hold(1'b1, v.zero_sp);
                end
                hold(1'b0, v.bit_mark);
                hold(1'b1, 2000);
            end
            K_RPT: begin
                hold(1'b0, v.lead_mark);
                hold(1'b1, v.lead_space);
                hold(1'b0, v.bit_mark);
                hold(1'b1, 2000);
            end
            default: begin
                hold(1'b0, 200);
                hold(1'b1, 2000);
            end
        endcase
    endtask

    task automatic check_output(input vec_t v, input int a0, input int r0, input int e0);
        check({v.name, ".avail"}, avail_cnt - a0, v.exp_avail);
        check({v.name, ".rpt"}, rpt_cnt - r0, v.exp_rpt);
        check({v.name, ".frame_err"}, err_cnt - e0, v.exp_err);
        check({v.name, ".ir_data"}, ir_data, v.exp_data);
        check({v.name, ".cmd_ok"}, {31'd0, cmd_ok}, {31'd0, v.exp_ok});
    endtask

    task automatic send_repeat_expect(input string name);
        int r0;
        r0 = rpt_cnt;
        hold(1'b0, 9000);
        hold(1'b1, 2250);
        hold(1'b0, 560);
        hold(1'b1, 2000);
        check(name, rpt_cnt - r0, 1);
    endtask

    initial begin
        int a0, r0, e0, found;
        logic [31:0] partial;

        vecs[0]  = '{"nominal",       K_FRAME, nec_word(8'h00, 8'h45), 9000, 4500, 560, 560, 1690, 32, -1, 0,    1, 0, 0, 32'hBA45FF00, 1'b1};
        vecs[1]  = '{"repeat",        K_RPT,   32'h0,                  9000, 2250, 560, 0,   0,    0,  -1, 0,    0, 1, 0, 32'hBA45FF00, 1'b1};
        vecs[2]  = '{"bit10_1000us",  K_FRAME, nec_word(8'h00, 8'h12), 9000, 4500, 560, 560, 1690, 32, 10, 1000, 0, 0, 1, 32'hBA45FF00, 1'b1};
        vecs[3]  = '{"noise_200us",   K_NOISE, 32'h0,                  0,    0,    0,   0,   0,    0,  -1, 0,    0, 0, 0, 32'hBA45FF00, 1'b1};
        vecs[4]  = '{"after_noise",   K_FRAME, nec_word(8'h10, 8'h22), 9000, 4500, 560, 560, 1690, 32, -1, 0,    1, 0, 0, 32'hDD22EF10, 1'b1};
        vecs[5]  = '{"all_min",       K_FRAME, 32'h12345678,           8000, 4000, 400, 400, 1400, 32, -1, 0,    1, 0, 0, 32'h12345678, 1'b0};
        vecs[6]  = '{"all_max",       K_FRAME, nec_word(8'h01, 8'h80), 10000, 5000, 750, 750, 1900, 32, -1, 0,   1, 0, 0, 32'h7F80FE01, 1'b1};
        vecs[7]  = '{"lead_short",    K_FRAME, nec_word(8'hAA, 8'h55), 7990, 4500, 560, 560, 1690, 4,  -1, 0,    0, 0, 0, 32'h7F80FE01, 1'b1};
        vecs[8]  = '{"bit_mark_long", K_FRAME, nec_word(8'h00, 8'h45), 9000, 4500, 760, 560, 1690, 2,  -1, 0,    0, 0, 1, 32'h7F80FE01, 1'b1};
        vecs[9]  = '{"zero_short",    K_FRAME, nec_word(8'h00, 8'h45), 9000, 4500, 560, 390, 1690, 2,  -1, 0,    0, 0, 1, 32'h7F80FE01, 1'b1};
        vecs[10] = '{"one_long",      K_FRAME, nec_word(8'hFF, 8'h00), 9000, 4500, 560, 560, 1910, 2,  -1, 0,    0, 0, 1, 32'h7F80FE01, 1'b1};
        vecs[11] = '{"lead_space_bad", K_FRAME, nec_word(8'h00, 8'h45), 9000, 3500, 560, 560, 1690, 2, -1, 0,    0, 0, 1, 32'h7F80FE01, 1'b1};
        vecs[12] = '{"rpt_min",       K_RPT,   32'h0,                  9000, 1800, 400, 0,   0,    0,  -1, 0,    0, 1, 0, 32'h7F80FE01, 1'b1};
        vecs[13] = '{"rpt_max",       K_RPT,   32'h0,                  9000, 2700, 750, 0,   0,    0,  -1, 0,    0, 1, 0, 32'h7F80FE01, 1'b1};
        vecs[14] = '{"rpt_space_bad", K_RPT,   32'h0,                  9000, 3000, 560, 0,   0,    0,  -1, 0,    0, 0, 1, 32'h7F80FE01, 1'b1};
        vecs[15] = '{"rpt_stop_long", K_RPT,   32'h0,                  9000, 2250, 760, 0,   0,    0,  -1, 0,    0, 0, 1, 32'h7F80FE01, 1'b1};
        vecs[16] = '{"zero_long",     K_FRAME, nec_word(8'h00, 8'h45), 9000, 4500, 560, 760, 1690, 2,  -1, 0,    0, 0, 1, 32'h7F80FE01, 1'b1};
        vecs[17] = '{"one_short",     K_FRAME, nec_word(8'hFF, 8'h00), 9000, 4500, 560, 560, 1390, 2,  -1, 0,    0, 0, 1, 32'h7F80FE01, 1'b1};

        repeat (3) @(negedge clock);
        check("reset.ir_data", ir_data, 32'h0);
        check("reset.avail", {31'd0, avail}, 32'd0);
        check("reset.rpt", {31'd0, rpt}, 32'd0);
        check("reset.frame_err", {31'd0, frame_err}, 32'd0);
        check("reset.cmd_ok", {31'd0, cmd_ok}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);

        for (int i = 0; i < 18; i++) begin
            a0 = avail_cnt;
            r0 = rpt_cnt;
            e0 = err_cnt;
            apply_stimulus(vecs[i]);
            check_output(vecs[i], a0, r0, e0);
        end

        // Leader accepted, then the space never ends: frame_err near 11000 us.
        e0 = err_cnt;
        found = -1;
        hold(1'b0, 9000);
        ir_signal = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clock);
            if (frame_err) begin
                found = i;
                break;
            end
        end
        check("space_timeout.in_range", {31'd0, (found >= 1095) && (found <= 1110)}, 32'd1);
        if (found < 0) $display("[TB] space_timeout: no frame_err seen within 12000 us");
        else $display("[TB] space_timeout: frame_err after %0d cycles", found);
        repeat (100) @(negedge clock);
        check("space_timeout.err_count", err_cnt - e0, 1);
        send_repeat_expect("space_timeout.idle_after");

        // A stuck mark times out silently and waits for the line to go idle.
        e0 = err_cnt;
        hold(1'b0, 12000);
        hold(1'b1, 2000);
        check("mark_timeout.err_count", err_cnt - e0, 0);
        send_repeat_expect("mark_timeout.idle_after");

        // Reset during bit 20, then a clean frame must decode.
        partial = nec_word(8'h00, 8'h16);
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int k = 0; k < 20; k++) begin
            hold(1'b0, 560);
            hold(1'b1, partial[k] ? 1690 : 560);
        end
        hold(1'b0, 300);
        reset_n = 1'b0;
        #1;
        check("midreset.ir_data", ir_data, 32'h0);
        check("midreset.cmd_ok", {31'd0, cmd_ok}, 32'd0);
        repeat (10) @(negedge clock);
        ir_signal = 1'b1;
        repeat (10) @(negedge clock);
        reset_n = 1'b1;
        repeat (200) @(negedge clock);
        a0 = avail_cnt;
        e0 = err_cnt;
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int k = 0; k < 32; k++) begin
            hold(1'b0, 560);
            hold(1'b1, partial[k] ? 1690 : 560);
        end
        hold(1'b0, 560);
        hold(1'b1, 2000);
        check("after_reset.avail", avail_cnt - a0, 1);
        check("after_reset.frame_err", err_cnt - e0, 0);
        check("after_reset.ir_data", ir_data, 32'hE916FF00);
        check("after_reset.cmd_ok", {31'd0, cmd_ok}, 32'd1);

        check("pulse_exclusive", excl_viol, 0);
        check("pulse_width", width_viol, 0);
        check("data_only_with_avail", data_viol, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
